// File: rtl/alarm_ctrl_pkg.sv
// alarm_pkg: shared types and constants for the alarm controller.
//   alarmState_e   - 3-bit state code driven out on the 'state' port
//   DEF_*          - default tick counts (Hz2 cycles) and limits
//   timerWidth()   - bits needed to hold a count of 0..maxVal
//   isSetState()   - true for the two clock/alarm adjust modes
package alarm_pkg;

  typedef enum logic [2:0] {
    RUN       = 3'd0,
    SET_TIME  = 3'd1,
    SET_ALARM = 3'd2,
    RING      = 3'd3,
    SNOOZE    = 3'd4
  } alarmState_e;

  localparam int unsigned DEF_SNOOZE_TICKS = 600;
  localparam int unsigned DEF_RING_TICKS   = 120;
  localparam int unsigned DEF_MAX_SNOOZE   = 3;
  localparam int unsigned DEF_REPEAT_DELAY = 4;

  function automatic int unsigned timerWidth(input int unsigned maxVal);
    return (maxVal < 2) ? 1 : int'($clog2(maxVal + 1));
  endfunction

  function automatic logic isSetState(input alarmState_e s);
    return (s == SET_TIME) || (s == SET_ALARM);
  endfunction

endpackage

// File: rtl/alarm_ctrl_if.sv
// alarm_ctrl_if: board-side switches/keys plus the datapath control outputs.
//   master - board / testbench side: drives switches and keys, reads controls
//   slave  - alarm_ctrl side: reads switches and keys, drives controls
interface alarm_ctrl_if;
  logic       time_set_sw;
  logic       alarm_set_sw;
  logic       hrs_sw;
  logic       run_sw;
  logic       arm_sw;
  logic       KEY1;
  logic       snooze_key;
  logic       stop_key;
  logic       alarm;
  logic       time_set_inc;
  logic       alarm_set_inc;
  logic       sethrs1min0;
  logic       run;
  logic       activatealarm;
  logic       alarmreset;
  logic       buzzer;
  logic [1:0] snooze_cnt;
  logic [2:0] state;

  modport master (
    output time_set_sw, alarm_set_sw, hrs_sw, run_sw, arm_sw,
           KEY1, snooze_key, stop_key, alarm,
    input  time_set_inc, alarm_set_inc, sethrs1min0, run, activatealarm,
           alarmreset, buzzer, snooze_cnt, state
  );

  modport slave (
    input  time_set_sw, alarm_set_sw, hrs_sw, run_sw, arm_sw,
           KEY1, snooze_key, stop_key, alarm,
    output time_set_inc, alarm_set_inc, sethrs1min0, run, activatealarm,
           alarmreset, buzzer, snooze_cnt, state
  );
endinterface

// File: rtl/alarm_ctrl_key_repeat.sv
// key_repeat: turns the advance key into increment requests.
//   clk, rst_n - Hz2 clock, async active-low reset
//   key_i      - advance key, already synchronous
//   clr_i      - restart hold counting (leaving or switching set modes)
//   fire_o     - combinational request: rising edge, or every cycle once the
//                key has been held REPEAT_DELAY consecutive cycles
module key_repeat
  import alarm_pkg::*;
#(
  parameter int unsigned REPEAT_DELAY = DEF_REPEAT_DELAY
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_i,
  input  logic clr_i,
  output logic fire_o
);

  localparam int unsigned CW = timerWidth(REPEAT_DELAY);
  localparam logic [CW-1:0] HOLD_MAX = CW'(REPEAT_DELAY);

  logic [CW-1:0] holdCnt_q, holdCnt_d;
  logic          keyPrev_q;

  // Hold counter saturates at HOLD_MAX; reaching it switches on auto-repeat.
  always_comb begin
    holdCnt_d = holdCnt_q;
    fire_o    = 1'b0;
    if (clr_i || !key_i) begin
      holdCnt_d = '0;
    end else begin
      fire_o = !keyPrev_q || (holdCnt_q == HOLD_MAX);
      if (holdCnt_q != HOLD_MAX) holdCnt_d = holdCnt_q + 1'b1;
    end
  end

  // keyPrev tracks the key unconditionally so a key already held when a
  // set mode is entered does not count as a fresh press.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      holdCnt_q <= '0;
      keyPrev_q <= 1'b0;
    end else begin
      holdCnt_q <= holdCnt_d;
      keyPrev_q <= key_i;
    end
  end

endmodule

// File: rtl/alarm_ctrl.sv
// alarm_ctrl: mode sequencer and ring/snooze scheduler for the alarm clock.
//   Hz2   - clock, all state changes on posedge
//   reset - async, active-low
//   bus   - alarm_ctrl_if.slave: switches/keys in, datapath controls out
// Every output is a register loaded from the next state and current inputs,
// so outputs always agree with the state code shown alongside them.
module alarm_ctrl
  import alarm_pkg::*;
#(
  parameter int unsigned SNOOZE_TICKS = DEF_SNOOZE_TICKS,
  parameter int unsigned RING_TICKS   = DEF_RING_TICKS,
  parameter int unsigned MAX_SNOOZE   = DEF_MAX_SNOOZE,
  parameter int unsigned REPEAT_DELAY = DEF_REPEAT_DELAY
) (
  input logic         Hz2,
  input logic         reset,
  alarm_ctrl_if.slave bus
);

  localparam int unsigned RW = timerWidth(RING_TICKS);
  localparam int unsigned SW = timerWidth(SNOOZE_TICKS);
  localparam logic [RW-1:0] RING_LAST   = RW'(RING_TICKS - 1);
  localparam logic [SW-1:0] SNOOZE_LOAD = SW'(SNOOZE_TICKS);
  localparam logic [1:0]    SNOOZE_MAX  = 2'(MAX_SNOOZE);

  alarmState_e   state_q, state_d;
  logic [RW-1:0] ringTimer_q, ringTimer_d;
  logic [SW-1:0] snoozeTimer_q, snoozeTimer_d;
  logic [1:0]    snoozeCnt_q, snoozeCnt_d;
  logic          inhibit_q, inhibit_d;
  logic          run_q, run_d;
  logic          activate_q, activate_d;
  logic          alarmReset_q, alarmReset_d;
  logic          buzzer_q, buzzer_d;
  logic          timeInc_q, timeInc_d;
  logic          alarmInc_q, alarmInc_d;
  logic          setHrs_q, setHrs_d;
  logic          setInhibit;
  logic          keyFire;
  logic          keyClr;

  // Restart the hold counter whenever we are not staying in one set mode.
  assign keyClr = !isSetState(state_d) ||
                  (isSetState(state_q) && (state_q != state_d));

  key_repeat #(.REPEAT_DELAY(REPEAT_DELAY)) u_keyRepeat (
    .clk    (Hz2),
    .rst_n  (reset),
    .key_i  (bus.KEY1),
    .clr_i  (keyClr),
    .fire_o (keyFire)
  );

  // Next state and timers. Set switches override everything; leaving RING
  // for any reason issues the single alarmreset pulse.
  always_comb begin
    state_d       = RUN;
    ringTimer_d   = ringTimer_q;
    snoozeTimer_d = snoozeTimer_q;
    snoozeCnt_d   = snoozeCnt_q;
    alarmReset_d  = 1'b0;
    setInhibit    = 1'b0;
    if (bus.time_set_sw || bus.alarm_set_sw) begin
      state_d = bus.time_set_sw ? SET_TIME : SET_ALARM;
      if (state_q == RING) alarmReset_d = 1'b1;
      if ((state_q == RING) || (state_q == SNOOZE)) snoozeCnt_d = '0;
    end else begin
      case (state_q)
        RUN: begin
          if (bus.alarm && bus.arm_sw && !inhibit_q) begin
            state_d     = RING;
            ringTimer_d = '0;
          end
        end
        RING: begin
          if (bus.stop_key || !bus.arm_sw || (ringTimer_q == RING_LAST)) begin
            alarmReset_d = 1'b1;
            snoozeCnt_d  = '0;
            setInhibit   = 1'b1;
          end else if (bus.snooze_key && (snoozeCnt_q < SNOOZE_MAX)) begin
            state_d       = SNOOZE;
            alarmReset_d  = 1'b1;
            snoozeCnt_d   = snoozeCnt_q + 2'd1;
            snoozeTimer_d = SNOOZE_LOAD;
          end else begin
            state_d = RING;
            if (ringTimer_q != RING_LAST) ringTimer_d = ringTimer_q + 1'b1;
          end
        end
        SNOOZE: begin
          if (bus.stop_key || !bus.arm_sw) begin
            snoozeCnt_d = '0;
            setInhibit  = 1'b1;
          end else if (snoozeTimer_q == SW'(1)) begin
            state_d     = RING;
            ringTimer_d = '0;
          end else begin
            state_d = SNOOZE;
            if (snoozeTimer_q != '0) snoozeTimer_d = snoozeTimer_q - 1'b1;
          end
        end
        default: state_d = RUN;
      endcase
    end
  end

  // Inhibit holds off re-ringing until the datapath match has gone away.
  always_comb begin
    inhibit_d = inhibit_q;
    if (setInhibit)     inhibit_d = 1'b1;
    else if (!bus.alarm) inhibit_d = 1'b0;
  end

  // Output values belonging to the state being entered.
  always_comb begin
    run_d      = 1'b0;
    activate_d = 1'b0;
    buzzer_d   = 1'b0;
    setHrs_d   = 1'b0;
    timeInc_d  = 1'b0;
    alarmInc_d = 1'b0;
    case (state_d)
      RUN: begin
        run_d      = bus.run_sw;
        activate_d = bus.arm_sw;
      end
      SET_TIME: begin
        setHrs_d  = bus.hrs_sw;
        timeInc_d = keyFire;
      end
      SET_ALARM: begin
        setHrs_d   = bus.hrs_sw;
        alarmInc_d = keyFire;
      end
      RING: begin
        buzzer_d   = 1'b1;
        run_d      = bus.run_sw;
        activate_d = bus.arm_sw;
      end
      SNOOZE: run_d = bus.run_sw;
      default: run_d = 1'b0;
    endcase
  end

  // State, timers and registered outputs.
  always_ff @(posedge Hz2 or negedge reset) begin
    if (!reset) begin
      state_q       <= RUN;
      ringTimer_q   <= '0;
      snoozeTimer_q <= '0;
      snoozeCnt_q   <= '0;
      inhibit_q     <= 1'b0;
      run_q         <= 1'b0;
      activate_q    <= 1'b0;
      alarmReset_q  <= 1'b0;
      buzzer_q      <= 1'b0;
      timeInc_q     <= 1'b0;
      alarmInc_q    <= 1'b0;
      setHrs_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      ringTimer_q   <= ringTimer_d;
      snoozeTimer_q <= snoozeTimer_d;
      snoozeCnt_q   <= snoozeCnt_d;
      inhibit_q     <= inhibit_d;
      run_q         <= run_d;
      activate_q    <= activate_d;
      alarmReset_q  <= alarmReset_d;
      buzzer_q      <= buzzer_d;
      timeInc_q     <= timeInc_d;
      alarmInc_q    <= alarmInc_d;
      setHrs_q      <= setHrs_d;
    end
  end

  assign bus.state         = state_q;
  assign bus.snooze_cnt    = snoozeCnt_q;
  assign bus.run           = run_q;
  assign bus.activatealarm = activate_q;
  assign bus.alarmreset    = alarmReset_q;
  assign bus.buzzer        = buzzer_q;
  assign bus.time_set_inc  = timeInc_q;
  assign bus.alarm_set_inc = alarmInc_q;
  assign bus.sethrs1min0   = setHrs_q;

endmodule
